// File: rtl/sar_logic_if.sv
// sar_logic_if: start/comparator/status/code bundle between the SAR controller
// (master) and the analog front end / digital back end (slave).
interface sar_logic_if #(
    parameter int N = 8
);
    logic         start;
    logic         cmp_out;
    logic         sample;
    logic         cmp_en;
    logic [N-1:0] dac;
    logic [N-1:0] dout;
    logic         valid;
    logic         busy;

    modport master (
        input  start, cmp_out,
        output sample, cmp_en, dac, dout, valid, busy
    );

    modport slave (
        output start, cmp_out,
        input  sample, cmp_en, dac, dout, valid, busy
    );
endinterface

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller for the SAR ADC.
// One N-bit conversion per accepted start; all outputs are registered.
// Optional feature macro SAR_CMP_SYNC_EN: routes cmp_out through a two-flop
// synchronizer and stretches COMPARE to three cycles (comparator strobed in
// the first, decision taken from the synchronizer at the end of the third).
module sar_logic #(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter bit CMP_INV       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    sar_logic_if.master bus
);
    localparam int           IDX_W = $clog2(N);
    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     result_q, result_d;

    logic             sample_q, sample_d;
    logic             cmp_en_q, cmp_en_d;
    logic [N-1:0]     dac_q, dac_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             dec;       // 1 = keep the trial bit
    logic             cmp_last;  // current cycle closes the COMPARE phase

`ifdef SAR_CMP_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] ph_q;

    // Two-flop synchronizer on the comparator and COMPARE sub-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            ph_q   <= 2'd0;
        end else begin
            sync_q <= {sync_q[0], bus.cmp_out};
            ph_q   <= (state_q == S_COMPARE && !cmp_last) ? ph_q + 2'd1 : 2'd0;
        end
    end

    assign cmp_last = (ph_q == 2'd2);
    assign dec      = sync_q[1] ^ CMP_INV;
`else
    assign cmp_last = 1'b1;
    assign dec      = bus.cmp_out ^ CMP_INV;
`endif

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SAMPLE;
                    result_d = '0;
                    cnt_d    = 4'(SAMPLE_CYCLES - 1);
                end
            end
            S_SAMPLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SETTLE;
                    idx_d   = IDX_W'(N - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SETTLE: begin
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (cmp_last) begin
                    result_d[idx_q] = dec;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moore outputs are derived from the state being entered so that
        // they appear registered in the same cycle as that state.
        sample_d = (state_d == S_SAMPLE);
        busy_d   = (state_d != S_IDLE);
        valid_d  = (state_d == S_DONE);
        // Strobe only on the first COMPARE cycle (entry from SETTLE).
        cmp_en_d = (state_d == S_COMPARE) && (state_q != S_COMPARE);
        dout_d   = (state_d == S_DONE) ? result_d : dout_q;

        case (state_d)
            S_SETTLE:  dac_d = result_d | (ONE << idx_d);
            S_COMPARE: dac_d = dac_q;
            default:   dac_d = '0;
        endcase
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            cmp_en_q <= 1'b0;
            dac_q    <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            sample_q <= sample_d;
            cmp_en_q <= cmp_en_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.sample = sample_q;
    assign bus.cmp_en = cmp_en_q;
    assign bus.dac    = dac_q;
    assign bus.dout   = dout_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;

endmodule

// File: doc/sar_logic.md
# sar_logic

Synchronous successive-approximation control for the SKY130 SAR ADC. Consumes the latched comparator decision delivered by the comparator output inverter stage and drives the capacitive DAC trial code. Produces one N-bit conversion result per start request, with sample/busy/valid status for the digital back end.

## Interface
- `N`, 8 — resolution in bits, 4..12.
- `SAMPLE_CYCLES`, 2 — track-phase length in clocks, 1..15.
- `CMP_INV`, 1 — 1: `cmp_out` arrives inverted through the inverter stage (0 means Vin ≥ Vdac); 0: true polarity (1 means Vin ≥ Vdac).

Ports:
- `clk` input 1 — conversion clock, rising-edge active.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — conversion request; level-sampled in IDLE only.
- `cmp_out` input 1 — comparator decision after the inverter stage.
- `sample` output 1 — high during track phase; closes the bootstrapped sampling switch.
- `cmp_en` output 1 — high during COMPARE cycles; strobes the comparator latch.
- `dac` output N — DAC trial code, MSB = bit N-1.
- `dout` output N — last completed result, held until the next DONE.
- `valid` output 1 — one-cycle pulse when `dout` updates.
- `busy` output 1 — high in every state except IDLE.

## Operation
- All outputs are registered (Moore); all of them reset to 0, and the FSM resets to IDLE.
- Decision `d` = `cmp_out ^ CMP_INV`. `d = 1` means keep the trial bit.
- IDLE: outputs idle, `dac` = 0. If `start` = 1, go to SAMPLE, clear the result register, and load the sample counter with SAMPLE_CYCLES-1.
- SAMPLE: `sample` = 1 and `busy` = 1. The counter decrements each cycle. At 0, go to SETTLE with bit index `i` = N-1.
- SETTLE: `dac` = result | (1<<i), `cmp_en` = 0. Next state is COMPARE.
- COMPARE: `dac` unchanged, `cmp_en` = 1. At the closing edge, result[i] = `d`.
  - If `i` > 0: decrement `i` and go to SETTLE.
  - Else: go to DONE.
- DONE: `dout` = result, `valid` = 1, `dac` = 0. Next state is IDLE unconditionally.
- `start` outside IDLE is ignored. It is not queued.
- `start` held high: a new conversion begins on the first IDLE cycle, so there is exactly one IDLE cycle between conversions.
- `cmp_out` is sampled only at COMPARE closing edges. It is don't-care elsewhere.
- Reset mid-conversion: asynchronous return to IDLE. All outputs go to 0 immediately, including `dout`. No `valid` pulse is generated.
- Codes saturate naturally:
  - All decisions = 1 gives `dout` = 2^N-1.
  - All decisions = 0 gives `dout` = 0.
  - No wrap-around arithmetic is used.

## Timing
- Let E0 be the edge at which `start` is seen in IDLE.
- `sample` and `busy` are high from E0 to E0+SAMPLE_CYCLES.
- Each bit takes 2 cycles (SETTLE and COMPARE). With SAR_CMP_SYNC_EN, each bit takes 4 cycles.
- DONE is entered at E0+SAMPLE_CYCLES+2N. `valid` and the new `dout` are visible in that cycle.
- `busy` falls at E0+SAMPLE_CYCLES+2N+1.
- Throughput with `start` held high: one result per SAMPLE_CYCLES+2N+2 cycles.
- The DAC has one full clock (SETTLE) to settle before the comparator strobe.

## Configuration
- `SAR_CMP_SYNC_EN` defined:
  - `cmp_out` passes through a two-flop synchronizer clocked by `clk`.
  - COMPARE lasts 3 cycles, with `cmp_en` high only in the first.
  - The decision is taken from the synchronizer output at the closing edge of the 3rd cycle.
  - Per-bit cost is 4 cycles.
- Undefined: `cmp_out` is used directly, COMPARE is 1 cycle, and there is no synchronizer logic.

## Test plan
- N=8, SAMPLE_CYCLES=2, CMP_INV=0. Behavioural comparator: `cmp_out` = (0xA5 ≥ `dac`) during `cmp_en`. Pulse `start`. Required: `dac` sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; `valid` pulse at E0+18 with `dout` = 0xA5; `busy` low at E0+19.
- Same setup with vin 0x00 and vin 0xFF. Required: `dout` = 0x00 and 0xFF respectively, with no overflow.
- CMP_INV=1 with an inverted comparator model, vin 0x3C. Required: `dout` = 0x3C.
- `start` pulsed again at E0+5. Required: ignored, a single `valid` pulse, and the same result. `start` held high: the second `sample` rise is at E0+20.
- `rst_n` low at E0+9. Required: all outputs are 0 within the same cycle, no `valid`, and a fresh `start` after release converts correctly.
- `SAR_CMP_SYNC_EN` defined, vin 0xA5. Required: `valid` at E0+34, `dout` = 0xA5, and `cmp_en` high for 1 of every 3 COMPARE cycles.
